// File: rtl/rng_sample_requester_if.sv
// Host-side and RNG-side signal bundle for rng_sample_requester.
// The slave modport is the requester itself; the master modport is its environment.
interface rng_sample_requester_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  start;
    logic [7:0]            num_samples;
    logic                  rng_call;
    logic [WORD_WIDTH-1:0] rng_data;
    logic                  rd_en;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  full;
    logic                  busy;
    logic                  done;
    logic [7:0]            zero_cnt;
    logic [7:0]            inf_cnt;
    logic [7:0]            nan_cnt;

    modport master (
        output start, num_samples, rng_data, rd_en,
        input  rng_call, rd_data, empty, full, busy, done, zero_cnt, inf_cnt, nan_cnt
    );

    modport slave (
        input  start, num_samples, rng_data, rd_en,
        output rng_call, rd_data, empty, full, busy, done, zero_cnt, inf_cnt, nan_cnt
    );
endinterface

// File: rtl/rng_sample_requester.sv
// Requests bursts of binary16 samples from an RNG, buffers them in a fall-through FIFO
// and keeps saturating zero/inf/NaN counts of the collected samples.
module rng_sample_requester #(
    parameter int WORD_WIDTH  = 16,
    parameter int DEPTH       = 8,
    parameter int RSP_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  nreset,
    rng_sample_requester_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALL = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_zero(input logic [WORD_WIDTH-1:0] w);
        return (w[14:0] == 15'd0);
    endfunction

    function automatic logic is_inf(input logic [WORD_WIDTH-1:0] w);
        return (w[14:10] == 5'd31) && (w[9:0] == 10'd0);
    endfunction

    function automatic logic is_nan(input logic [WORD_WIDTH-1:0] w);
        return (w[14:10] == 5'd31) && (w[9:0] != 10'd0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic hit);
        logic [7:0] r;
        if (hit && (c != 8'd255)) r = c + 8'd1;
        else                      r = c;
        return r;
    endfunction

    state_t                state_r, next_state_s;
    logic [7:0]            remaining_r;
    logic [2:0]            lat_r;
    logic                  rng_call_r, done_r, busy_r;
    logic                  call_s, done_s, busy_s;
    logic [AW:0]           wr_ptr_r, rd_ptr_r;
    logic [WORD_WIDTH-1:0] mem_r [DEPTH];
    logic [7:0]            zero_cnt_r, inf_cnt_r, nan_cnt_r;
    logic                  empty_s, full_s, accept_s, capture_s, pop_s, push_s;

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign accept_s  = (state_r == IDLE) && bus.start;
    assign capture_s = (state_r == WAIT) && (lat_r == 3'd0);
    assign pop_s     = bus.rd_en && !empty_s;
    // A simultaneous pop frees the slot, so a push is legal even when full.
    assign push_s    = capture_s && (!full_s || pop_s);

    // State register and registered handshake/status outputs.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_r    <= IDLE;
            rng_call_r <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            rng_call_r <= call_s;
            done_r     <= done_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) next_state_s = (bus.num_samples != 8'd0) ? CALL : DONE;
                else           next_state_s = IDLE;
            end
            CALL: begin
                if (!full_s) next_state_s = WAIT;
                else         next_state_s = CALL;
            end
            WAIT: begin
                if (capture_s) next_state_s = (remaining_r == 8'd1) ? DONE : CALL;
                else           next_state_s = WAIT;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode; values are registered so they appear in the state they describe.
    always_comb begin
        call_s = (state_r == CALL) && !full_s;
        done_s = (next_state_s == DONE);
        busy_s = (next_state_s != IDLE);
    end

    // Burst bookkeeping: remaining samples and response-latency countdown.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            remaining_r <= 8'd0;
            lat_r       <= 3'd0;
        end else begin
            if (accept_s)       remaining_r <= bus.num_samples;
            else if (capture_s) remaining_r <= remaining_r - 8'd1;
            if (call_s)                                    lat_r <= 3'(RSP_LATENCY);
            else if ((state_r == WAIT) && (lat_r != 3'd0)) lat_r <= lat_r - 3'd1;
        end
    end

    // Sample FIFO storage and wrap-bit pointers.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WORD_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= bus.rng_data;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
        end
    end

    // Saturating class counters, cleared when a burst is accepted.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            zero_cnt_r <= 8'd0;
            inf_cnt_r  <= 8'd0;
            nan_cnt_r  <= 8'd0;
        end else if (accept_s) begin
            zero_cnt_r <= 8'd0;
            inf_cnt_r  <= 8'd0;
            nan_cnt_r  <= 8'd0;
        end else if (capture_s) begin
            zero_cnt_r <= sat_inc(zero_cnt_r, is_zero(bus.rng_data));
            inf_cnt_r  <= sat_inc(inf_cnt_r, is_inf(bus.rng_data));
            nan_cnt_r  <= sat_inc(nan_cnt_r, is_nan(bus.rng_data));
        end
    end

    assign bus.rng_call = rng_call_r;
    assign bus.done     = done_r;
    assign bus.busy     = busy_r;
    assign bus.empty    = empty_s;
    assign bus.full     = full_s;
    assign bus.rd_data  = mem_r[rd_ptr_r[AW-1:0]];
    assign bus.zero_cnt = zero_cnt_r;
    assign bus.inf_cnt  = inf_cnt_r;
    assign bus.nan_cnt  = nan_cnt_r;
endmodule

// File: tb/tb_rng_sample_requester.sv
// Directed-plus-random bench for rng_sample_requester with a queue-based FIFO model
// and an arithmetic binary16 classifier as reference.
module tb_rng_sample_requester;
    localparam int RSP_LATENCY = 1;
    localparam int DEPTH       = 8;

    logic clock = 1'b0;
    logic nreset;

    rng_sample_requester_if #(.WORD_WIDTH(16)) bus ();

    rng_sample_requester #(
        .WORD_WIDTH(16), .DEPTH(DEPTH), .RSP_LATENCY(RSP_LATENCY)
    ) dut (
        .clock(clock), .nreset(nreset), .bus(bus)
    );

    always #5 clock = ~clock;

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          cyc       = 0;
    int          call_cnt  = 0;
    int          served_cnt = 0;
    int          done_cnt  = 0;
    int          double_cnt = 0;
    logic        prev_call = 1'b0;
    int          call_cyc[$];
    logic [15:0] word_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] burst_words[$];
    logic [15:0] rsp_word;

    always @(posedge clock) cyc++;

    // Observe call pulses and done pulses away from the active edge.
    always @(negedge clock) begin
        if (bus.rng_call === 1'b1) begin
            call_cnt++;
            call_cyc.push_back(cyc);
            if (prev_call) double_cnt++;
        end
        if (bus.done === 1'b1) done_cnt++;
        prev_call = (bus.rng_call === 1'b1);
    end

    // RNG model: a word is presented RSP_LATENCY edges after the call is sampled.
    initial begin
        bus.rng_data = 16'h1234;
        forever begin
            @(posedge clock);
            if (call_cnt > served_cnt) begin
                served_cnt = call_cnt;
                repeat (RSP_LATENCY - 1) @(posedge clock);
                #1;
                if (word_q.size() > 0) rsp_word = word_q.pop_front();
                else                   rsp_word = 16'($urandom);
                bus.rng_data = rsp_word;
                exp_q.push_back(rsp_word);
                burst_words.push_back(rsp_word);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // 0 = ordinary, 1 = zero, 2 = infinity, 3 = NaN
    function automatic int cls(input int w);
        int e, m;
        e = (w / 1024) % 32;
        m = w % 1024;
        if ((w % 32768) == 0) return 1;
        if (e == 31) return (m == 0) ? 2 : 3;
        return 0;
    endfunction

    function automatic logic [15:0] rand_word();
        case ($urandom_range(5))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'h7C00;
            3:       return 16'hFC00;
            4:       return 16'h7C00 | 16'($urandom_range(1, 1023));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int n);
        burst_words.delete();
        bus.num_samples = 8'(n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() > 0) e = {16'd0, exp_q.pop_front()};
        else                  e = 32'hDEAD_BEEF;
        check(tag, {16'd0, bus.rd_data}, e);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int pop_pct);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (!bus.empty && ($urandom_range(99) < pop_pct)) pop_check({tag, "_pop"});
            else tick();
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 64 && (bus.empty !== 1'b1); i++) pop_check({tag, "_pop"});
        check({tag, "_empty"}, 32'(bus.empty), 32'd1);
        check({tag, "_model_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_counters(input string tag);
        int z, f, n, c;
        z = 0; f = 0; n = 0;
        foreach (burst_words[i]) begin
            c = cls(32'(burst_words[i]));
            if (c == 1)      z++;
            else if (c == 2) f++;
            else if (c == 3) n++;
        end
        check({tag, "_zero_cnt"}, 32'(bus.zero_cnt), 32'((z > 255) ? 255 : z));
        check({tag, "_inf_cnt"},  32'(bus.inf_cnt),  32'((f > 255) ? 255 : f));
        check({tag, "_nan_cnt"},  32'(bus.nan_cnt),  32'((n > 255) ? 255 : n));
    endtask

    initial begin
        int base_calls, base_done, base_idx, n;

        // Reset with start held high and a live-looking RNG word.
        nreset = 1'b0;
        bus.start = 1'b1;
        bus.num_samples = 8'd5;
        bus.rd_en = 1'b0;
        repeat (3) tick();
        check("rst_rng_call", 32'(bus.rng_call), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_empty",    32'(bus.empty),    32'd1);
        check("rst_full",     32'(bus.full),     32'd0);
        check("rst_rd_data",  32'(bus.rd_data),  32'd0);
        check("rst_zero_cnt", 32'(bus.zero_cnt), 32'd0);
        check("rst_inf_cnt",  32'(bus.inf_cnt),  32'd0);
        check("rst_nan_cnt",  32'(bus.nan_cnt),  32'd0);
        bus.start = 1'b0;
        nreset = 1'b1;
        repeat (5) tick();
        check("rst_no_burst_busy",  32'(bus.busy), 32'd0);
        check("rst_no_burst_calls", 32'(call_cnt), 32'd0);

        // Three directed samples: one, zero, quiet NaN.
        word_q = '{16'h3C00, 16'h0000, 16'h7E00};
        base_calls = call_cnt; base_done = done_cnt; base_idx = call_cyc.size();
        do_start(3);
        check("b3_call_after_e0", 32'(bus.rng_call), 32'd0);
        tick();
        check("b3_call_after_e1", 32'(bus.rng_call), 32'd1);
        wait_done("b3", 40, 0);
        check("b3_busy_at_done", 32'(bus.busy), 32'd1);
        tick();
        check("b3_busy_after", 32'(bus.busy), 32'd0);
        check("b3_done_after", 32'(bus.done), 32'd0);
        check("b3_calls", 32'(call_cnt - base_calls), 32'd3);
        check("b3_gap01", 32'(call_cyc[base_idx+1] - call_cyc[base_idx]), 32'(RSP_LATENCY + 2));
        check("b3_gap12", 32'(call_cyc[base_idx+2] - call_cyc[base_idx+1]), 32'(RSP_LATENCY + 2));
        check_counters("b3");
        drain("b3");
        check("b3_done_pulses", 32'(done_cnt - base_done), 32'd1);

        // Twelve random samples against an eight-entry FIFO without popping.
        for (int i = 0; i < 12; i++) word_q.push_back(rand_word());
        base_calls = call_cnt; base_done = done_cnt;
        do_start(12);
        for (int i = 0; i < 100 && (bus.full !== 1'b1); i++) tick();
        repeat (10) tick();
        check("b12_full",       32'(bus.full), 32'd1);
        check("b12_calls_held", 32'(call_cnt - base_calls), 32'(DEPTH));
        check("b12_busy",       32'(bus.busy), 32'd1);
        pop_check("b12_pop1");
        repeat (10) tick();
        check("b12_calls_one_more", 32'(call_cnt - base_calls), 32'(DEPTH + 1));
        check("b12_full_again",     32'(bus.full), 32'd1);
        pop_check("b12_pop2");
        tick();
        tick();
        pop_check("b12_pop_at_capture");
        check("b12_full_after_pop_push", 32'(bus.full),  32'd0);
        check("b12_not_empty",           32'(bus.empty), 32'd0);
        wait_done("b12", 300, 100);
        drain("b12");
        check("b12_calls", 32'(call_cnt - base_calls), 32'd12);
        check_counters("b12");
        check("b12_done_pulses", 32'(done_cnt - base_done), 32'd1);

        // Zero-length burst: done only, no request.
        base_calls = call_cnt;
        do_start(0);
        check("b0_done", 32'(bus.done), 32'd1);
        tick();
        check("b0_done_drop", 32'(bus.done), 32'd0);
        check("b0_busy",      32'(bus.busy), 32'd0);
        check("b0_calls",     32'(call_cnt - base_calls), 32'd0);

        // Random-length burst with random pops.
        n = $urandom_range(5, 20);
        for (int i = 0; i < n; i++) word_q.push_back(rand_word());
        base_calls = call_cnt;
        do_start(n);
        wait_done("brnd", 400, 50);
        drain("brnd");
        check("brnd_calls", 32'(call_cnt - base_calls), 32'(n));
        check_counters("brnd");

        // Infinity saturation over 255 + 45 samples, cleared by the second start.
        for (int i = 0; i < 255; i++) word_q.push_back(16'h7C00);
        do_start(255);
        wait_done("bsat", 1200, 100);
        drain("bsat");
        check_counters("bsat");
        check("bsat_inf_255", 32'(bus.inf_cnt), 32'd255);
        for (int i = 0; i < 45; i++) word_q.push_back(16'h7C00);
        do_start(45);
        check("bsat_inf_cleared", 32'(bus.inf_cnt), 32'd0);
        wait_done("bsat2", 300, 100);
        drain("bsat2");
        check_counters("bsat2");

        // Reset while waiting for a response: the late word must not land.
        word_q.push_back(16'h5555);
        do_start(4);
        tick();
        check("rw_call", 32'(bus.rng_call), 32'd1);
        tick();
        nreset = 1'b0;
        tick();
        check("rw_rng_call", 32'(bus.rng_call), 32'd0);
        check("rw_empty",    32'(bus.empty),    32'd1);
        check("rw_busy",     32'(bus.busy),     32'd0);
        nreset = 1'b1;
        exp_q.delete();
        word_q.delete();
        repeat (6) tick();
        check("rw_still_empty", 32'(bus.empty), 32'd1);
        check("rw_idle",        32'(bus.busy),  32'd0);

        check("single_cycle_calls", 32'(double_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
